// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART: configurable width, bit period, parity and stop bits,
// with a run-time loopback select feeding the transmitter back into the receiver.
module uart_cfg #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT     = 16,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [INPUT_DATA_WIDTH-1:0] i_data,
  output logic                        o_busy,
  output logic                        serial_out,
  input  logic                        serial_in,
  input  logic                        loopback,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic                        data_is_valid,
  output logic                        rx_error,
  output logic                        parity_error
);

  localparam int W     = INPUT_DATA_WIDTH;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY == 2);

  if (W < 1 || W > 16 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_cfg: unsupported parameter combination");
  end

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0] tx_bit_q, tx_bit_d;
  logic [W-1:0]     tx_shift_q, tx_shift_d, tx_shift_nx;
  logic             tx_par_q, tx_par_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_bit_end;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + CNT_W'(1);
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_line_d   = tx_line_q;
    tx_shift_nx = tx_shift_q >> 1;
    tx_bit_end  = (tx_cnt_q == CNT_LAST);
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (enable) begin
          tx_state_d = TX_START;
          tx_shift_d = i_data;
          tx_par_d   = (^i_data) ^ ODD;
          tx_line_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          tx_line_d  = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d = '0;
            if (PARITY != 0) begin
              tx_state_d = TX_PAR;
              tx_line_d  = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_line_d  = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + BIT_W'(1);
            tx_shift_d = tx_shift_nx;
            tx_line_d  = tx_shift_nx[0];
          end
        end
      end
      TX_PAR: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_STOP;
          tx_line_d  = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
          else                       tx_bit_d   = tx_bit_q + BIT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign o_busy     = (tx_state_q != TX_IDLE);
  assign serial_out = tx_line_q;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0] rx_bit_q, rx_bit_d;
  logic [W-1:0]     rx_word_q, rx_word_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic             rx_pbit_q, rx_pbit_d;
  logic             armed_q, armed_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
  logic             rx_line, rx_sample;

  assign rx_line = sync2_q;

  always_comb begin
    sync1_d    = loopback ? tx_line_q : serial_in;
    sync2_d    = sync1_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_word_d  = rx_word_q;
    rdata_d    = rdata_q;
    rx_pbit_d  = rx_pbit_q;
    armed_d    = armed_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    rx_sample  = (rx_cnt_q == CNT_LAST);
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        // A low line only starts a frame once it has been seen high, so a break gives one error.
        if (rx_line) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d    = 1'b0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (rx_line) begin
            rx_state_d = RX_IDLE;
            armed_d    = 1'b1;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
            rx_word_d  = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_cnt_d  = '0;
          rx_word_d = rx_word_q | (W'(rx_line) << rx_bit_q);
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end
      end
      RX_PAR: begin
        if (rx_sample) begin
          rx_cnt_d   = '0;
          rx_pbit_d  = rx_line;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (!rx_line) begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end else if (PARITY != 0 && (((^rx_word_q) ^ ODD) != rx_pbit_q)) begin
            perr_d  = 1'b1;
            armed_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            rdata_d = rx_word_q;
            armed_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_word_q  <= '0;
      rdata_q    <= '0;
      rx_pbit_q  <= 1'b0;
      armed_q    <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_word_q  <= rx_word_d;
      rdata_q    <= rdata_d;
      rx_pbit_q  <= rx_pbit_d;
      armed_q    <= armed_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
    end
  end

  assign received_data = rdata_q;
  assign data_is_valid = valid_q;
  assign rx_error      = ferr_q;
  assign parity_error  = perr_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: three framing configurations checked against a
// frame-level model (bit lists, parity by counting ones, latency formulas).
module tb_uart_cfg;

  function automatic int cfg_w(int i); return (i == 1) ? 7 : 8; endfunction
  function automatic int cfg_p(int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
  function automatic int cfg_s(int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int cfg_c(int i); return (i == 0) ? 16 : ((i == 1) ? 8 : 4); endfunction

  function automatic int nbits(int i);
    return 1 + cfg_w(i) + ((cfg_p(i) != 0) ? 1 : 0) + cfg_s(i);
  endfunction

  function automatic logic par_of(int i, logic [15:0] d);
    int ones = 0;
    for (int k = 0; k < cfg_w(i); k++) ones += int'(d[k]);
    return (cfg_p(i) == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  function automatic logic fbit(int i, logic [15:0] d, int b);
    if (b == 0) return 1'b0;
    if (b <= cfg_w(i)) return d[b-1];
    if (cfg_p(i) != 0 && b == cfg_w(i) + 1) return par_of(i, d);
    return 1'b1;
  endfunction

  function automatic logic [15:0] mask(int i, logic [15:0] d);
    return d & 16'((32'd1 << cfg_w(i)) - 1);
  endfunction

  // cycles from first synchronised low to the result pulse
  function automatic int unsigned rx_lat(int i);
    return cfg_c(i) / 2 + (cfg_w(i) + ((cfg_p(i) != 0) ? 1 : 0) + 1) * cfg_c(i) + 1;
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic [2:0] en, lb, sin;
  logic [15:0] din [3];
  logic busy0, busy1, busy2, so0, so1, so2, v0, v1, v2, re0, re1, re2, pe0, pe1, pe2;
  logic [7:0] rd0, rd2;
  logic [6:0] rd1;
  logic [2:0] busy, so, vld, rerr, perr;
  logic [15:0] rdv [3];

  always #5 clk = ~clk;

  always_comb begin
    busy = {busy2, busy1, busy0};
    so   = {so2, so1, so0};
    vld  = {v2, v1, v0};
    rerr = {re2, re1, re0};
    perr = {pe2, pe1, pe0};
    rdv[0] = {8'h00, rd0};
    rdv[1] = {9'h000, rd1};
    rdv[2] = {8'h00, rd2};
  end

  uart_cfg #(.INPUT_DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(rst), .enable(en[0]), .i_data(din[0][7:0]), .o_busy(busy0),
    .serial_out(so0), .serial_in(sin[0]), .loopback(lb[0]), .received_data(rd0),
    .data_is_valid(v0), .rx_error(re0), .parity_error(pe0));

  uart_cfg #(.INPUT_DATA_WIDTH(7), .CLKS_PER_BIT(8), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(rst), .enable(en[1]), .i_data(din[1][6:0]), .o_busy(busy1),
    .serial_out(so1), .serial_in(sin[1]), .loopback(lb[1]), .received_data(rd1),
    .data_is_valid(v1), .rx_error(re1), .parity_error(pe1));

  uart_cfg #(.INPUT_DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(rst), .enable(en[2]), .i_data(din[2][7:0]), .o_busy(busy2),
    .serial_out(so2), .serial_in(sin[2]), .loopback(lb[2]), .received_data(rd2),
    .data_is_valid(v2), .rx_error(re2), .parity_error(pe2));

  int unsigned cyc = 0;
  int unsigned nval [3] = '{0, 0, 0};
  int unsigned nrer [3] = '{0, 0, 0};
  int unsigned nper [3] = '{0, 0, 0};
  int unsigned lastp [3] = '{0, 0, 0};
  logic [15:0] good [3] = '{16'h0, 16'h0, 16'h0};
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i])  begin nval[i] <= nval[i] + 1; lastp[i] <= cyc; end
      if (rerr[i]) begin nrer[i] <= nrer[i] + 1; lastp[i] <= cyc; end
      if (perr[i]) begin nper[i] <= nper[i] + 1; lastp[i] <= cyc; end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Sends one word, checks the serial waveform bit by bit and, in loopback, the received result.
  task automatic send(input int i, input logic [15:0] d, input bit chk_rx,
                      output int unsigned n, output logic pb);
    int unsigned c, f, bad, wt, sv, se, sq;
    c = cfg_c(i); f = nbits(i) * c; wt = 0; bad = 0; pb = 1'b0;
    while (busy[i] && wt < 2000) begin tick(); wt++; end
    if (busy[i]) check("idle_wait", 32'(busy[i]), 32'd0);
    sv = nval[i]; se = nrer[i]; sq = nper[i];
    din[i] = d; en[i] = 1'b1; n = cyc;
    tick();
    en[i] = 1'b0; din[i] = 16'($urandom);
    for (int k = 1; k <= int'(f); k++) begin
      if (so[i] !== fbit(i, d, (k - 1) / int'(c)) || busy[i] !== 1'b1) bad++;
      if (k == (cfg_w(i) + 1) * int'(c) + int'(c) / 2) pb = so[i];
      tick();
    end
    check("tx_wave", bad, 32'd0);
    check("busy_fall", 32'(busy[i]), 32'd0);
    if (chk_rx) begin
      while (cyc <= n + 3 + rx_lat(i)) tick();
      check("rx_count", nval[i] - sv, 32'd1);
      check("rx_cycle", lastp[i], n + 3 + rx_lat(i));
      check("rx_word", 32'(rdv[i]), 32'(mask(i, d)));
      check("rx_errs", (nrer[i] - se) + (nper[i] - sq), 32'd0);
      good[i] = mask(i, d);
    end
  endtask

  task automatic drive_rx(input int i, input logic [15:0] d, input bit bad_par,
                          input bit bad_stop, output int unsigned t0);
    int c;
    logic b;
    c = cfg_c(i);
    t0 = cyc;
    for (int k = 0; k < nbits(i); k++) begin
      b = fbit(i, d, k);
      if (bad_par && cfg_p(i) != 0 && k == cfg_w(i) + 1) b = ~b;
      if (bad_stop && k == nbits(i) - cfg_s(i)) b = 1'b0;
      sin[i] = b;
      repeat (c) tick();
    end
    sin[i] = 1'b1;
    repeat (2 * c) tick();
  endtask

  typedef struct {
    int          dut;
    logic [15:0] data;
    logic        pbit;
    logic [15:0] word;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int unsigned n, pn, t0, sv, se, sq, f, hi;
    logic pb, bp, bs;
    logic [15:0] d;
    int i, ev, ee, eq;

    tbl[0] = '{0, 16'h00A5, 1'b1, 16'h00A5};
    tbl[1] = '{1, 16'h0000, 1'b1, 16'h0000};
    tbl[2] = '{1, 16'h007F, 1'b0, 16'h007F};
    tbl[3] = '{1, 16'h00FF, 1'b0, 16'h007F};
    tbl[4] = '{2, 16'h003C, 1'b0, 16'h003C};
    tbl[5] = '{0, 16'h0000, 1'b1, 16'h0000};
    tbl[6] = '{2, 16'h0007, 1'b1, 16'h0007};
    tbl[7] = '{0, 16'h00FF, 1'b1, 16'h00FF};

    rst = 1'b1; en = '0; lb = '1; sin = '1;
    for (int k = 0; k < 3; k++) din[k] = '0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_line", 32'(so[k]), 32'd1);
      check("rst_pulses", 32'({vld[k], rerr[k], perr[k]}), 32'd0);
      check("rst_rdata", 32'(rdv[k]), 32'd0);
    end
    rst = 1'b0;
    repeat (4) tick();

    // Directed loopback vectors; consecutive entries on one DUT run back to back.
    pn = 0;
    for (int j = 0; j < 8; j++) begin
      send(tbl[j].dut, tbl[j].data, 1'b1, n, pb);
      check("vec_pbit", 32'(pb), 32'(tbl[j].pbit));
      check("vec_word", 32'(rdv[tbl[j].dut]), 32'(tbl[j].word));
      if (j == 0) check("dv_n156", lastp[0] - n, 32'd156);
      if (j > 0 && tbl[j-1].dut == tbl[j].dut)
        check("b2b_gap", n - pn, 32'(nbits(tbl[j].dut) * cfg_c(tbl[j].dut) + 1));
      pn = n;
    end

    // Wrong parity on external line, even parity config.
    lb[2] = 1'b0;
    repeat (8) tick();
    sv = nval[2]; se = nrer[2]; sq = nper[2];
    drive_rx(2, 16'h003C, 1'b1, 1'b0, t0);
    check("perr_count", nper[2] - sq, 32'd1);
    check("perr_novalid", (nval[2] - sv) + (nrer[2] - se), 32'd0);
    check("perr_keep", 32'(rdv[2]), 32'(good[2]));
    check("perr_cycle", lastp[2], t0 + 2 + rx_lat(2));

    // Break for three frame times, then a clean frame.
    lb[0] = 1'b0;
    repeat (8) tick();
    sv = nval[0]; se = nrer[0]; sq = nper[0];
    sin[0] = 1'b0;
    repeat (3 * 160) tick();
    sin[0] = 1'b1;
    repeat (32) tick();
    check("break_err", nrer[0] - se, 32'd1);
    check("break_other", (nval[0] - sv) + (nper[0] - sq), 32'd0);
    drive_rx(0, 16'h0055, 1'b0, 1'b0, t0);
    check("post_break_valid", nval[0] - sv, 32'd1);
    check("post_break_word", 32'(rdv[0]), 32'h55);
    good[0] = 16'h0055;

    // Short glitch, then a second enable while busy.
    sv = nval[0]; se = nrer[0]; sq = nper[0];
    sin[0] = 1'b0;
    repeat (4) tick();
    sin[0] = 1'b1;
    repeat (40) tick();
    check("glitch_nopulse", (nval[0] - sv) + (nrer[0] - se) + (nper[0] - sq), 32'd0);
    f = 160;
    din[0] = 16'h0003; en[0] = 1'b1; n = cyc;
    tick();
    en[0] = 1'b0;
    repeat (20) tick();
    check("busy_mid", 32'(busy[0]), 32'd1);
    din[0] = 16'h00F0; en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    for (int k = 0; k < 400 && busy[0]; k++) tick();
    check("single_frame_end", cyc, n + f + 1);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy[0] || !so[0]) hi++;
      tick();
    end
    check("no_second_frame", hi, 32'd0);

    // Reset in the middle of the data bits.
    lb[0] = 1'b1;
    repeat (4) tick();
    sv = nval[0]; se = nrer[0]; sq = nper[0];
    din[0] = 16'h005A; en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    repeat (48) tick();
    rst = 1'b1;
    tick();
    check("midrst_line", 32'(so[0]), 32'd1);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0;
    repeat (320) tick();
    check("midrst_nopulse", (nval[0] - sv) + (nrer[0] - se) + (nper[0] - sq), 32'd0);
    check("midrst_rdata", 32'(rdv[0]), 32'd0);
    good[0] = '0;
    send(0, 16'h0081, 1'b1, n, pb);

    // Random loopback traffic on all three configurations.
    lb = '1;
    repeat (8) tick();
    for (int r = 0; r < 9; r++) begin
      send(r % 3, 16'($urandom), 1'b1, n, pb);
    end

    // Random external frames with occasional parity or stop corruption.
    lb[0] = 1'b0; lb[2] = 1'b0;
    repeat (8) tick();
    for (int r = 0; r < 12; r++) begin
      i  = (r % 2 == 1) ? 2 : 0;
      d  = 16'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 4) == 0);
      sv = nval[i]; se = nrer[i]; sq = nper[i];
      ev = 0; ee = 0; eq = 0;
      if (bs) ee = 1;
      else if (bp && cfg_p(i) != 0) eq = 1;
      else begin ev = 1; good[i] = mask(i, d); end
      drive_rx(i, d, bp, bs, t0);
      check("rnd_rx_kind", (nval[i] - sv) * 100 + (nrer[i] - se) * 10 + (nper[i] - sq),
            32'(ev * 100 + ee * 10 + eq));
      check("rnd_rx_cycle", lastp[i], t0 + 2 + rx_lat(i));
      check("rnd_rx_word", 32'(rdv[i]), 32'(good[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
